// File: rtl/rr_mux_arbiter_pkg.sv
// Shared types and constants for the round-robin 4:1 mux arbiter.
// Holds the FSM state encoding and the rotating-priority winner search.
package rr_mux_arbiter_pkg;

    localparam int unsigned NUM_REQ = 4;
    localparam int unsigned SEL_W   = 2;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_e;

    // First valid requester found scanning upward from start, wrapping modulo NUM_REQ.
    function automatic logic [SEL_W-1:0] rr_pick(
        input logic [NUM_REQ-1:0] valid,
        input logic [SEL_W-1:0]   start
    );
        logic [SEL_W-1:0] pick;
        logic [SEL_W-1:0] idx;
        logic             found;
        pick  = start;
        found = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = start + SEL_W'(k);
            if (!found && valid[idx]) begin
                pick  = idx;
                found = 1'b1;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/rr_mux_arbiter_mux.sv
// Shared 4:1 data multiplexer; the select comes straight from the arbiter's grant.
module mux_2
    import rr_mux_arbiter_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic [WIDTH-1:0] in0,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic [WIDTH-1:0] in3,
    input  logic [SEL_W-1:0] sel,
    output logic [WIDTH-1:0] out
);

    // Select one of the four payloads.
    always_comb begin
        out = in0;
        case (sel)
            2'd0:    out = in0;
            2'd1:    out = in1;
            2'd2:    out = in2;
            2'd3:    out = in3;
            default: out = in0;
        endcase
    end

endmodule

// File: rtl/rr_mux_arbiter.sv
// Round-robin arbiter that funnels four requesters through one shared mux
// into a single-entry output register with valid/ready handshaking.
module rr_mux_arbiter
    import rr_mux_arbiter_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NUM_REQ-1:0]    req_valid,
    input  logic [DATA_WIDTH-1:0] req_data0,
    input  logic [DATA_WIDTH-1:0] req_data1,
    input  logic [DATA_WIDTH-1:0] req_data2,
    input  logic [DATA_WIDTH-1:0] req_data3,
    output logic [NUM_REQ-1:0]    req_ready,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [SEL_W-1:0]      grant_sel,
    output logic [7:0]            xfer_cnt
);

    arb_state_e            state_r;
    arb_state_e            state_nxt_s;
    logic [SEL_W-1:0]      ptr_r;
    logic [SEL_W-1:0]      last_sel_r;
    logic [SEL_W-1:0]      winner_s;
    logic                  any_req_s;
    logic                  can_accept_s;
    logic                  xfer_s;
    logic [DATA_WIDTH-1:0] mux_out_s;
    logic [DATA_WIDTH-1:0] out_data_r;
    logic [7:0]            xfer_cnt_r;

    // Arbitration is re-evaluated every cycle from the current pointer.
    always_comb begin
        winner_s     = rr_pick(req_valid, ptr_r);
        any_req_s    = |req_valid;
        can_accept_s = (state_r == IDLE) || out_ready;
    end

    // One-hot accept toward the winner; forced low while reset is held.
    always_comb begin
        req_ready = {NUM_REQ{1'b0}};
        if (rst_n && can_accept_s && any_req_s) begin
            req_ready[winner_s] = 1'b1;
        end else begin
            req_ready = {NUM_REQ{1'b0}};
        end
    end

    // Grant tracks the winner and keeps its last value when nobody requests.
    always_comb begin
        grant_sel = {SEL_W{1'b0}};
        if (!rst_n) begin
            grant_sel = {SEL_W{1'b0}};
        end else if (any_req_s) begin
            grant_sel = winner_s;
        end else begin
            grant_sel = last_sel_r;
        end
    end

    assign xfer_s = |(req_valid & req_ready);

    mux_2 #(
        .WIDTH (DATA_WIDTH)
    ) u_mux (
        .in0 (req_data0),
        .in1 (req_data1),
        .in2 (req_data2),
        .in3 (req_data3),
        .sel (grant_sel),
        .out (mux_out_s)
    );

    // Next-state logic: a stalled BUSY holds; draining with no new transfer returns to IDLE.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (xfer_s) begin
                    state_nxt_s = BUSY;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            BUSY: begin
                if (!out_ready) begin
                    state_nxt_s = BUSY;
                end else if (xfer_s) begin
                    state_nxt_s = BUSY;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // State, pointer, payload and transfer counter all move together on an accepted transfer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= IDLE;
            ptr_r      <= {SEL_W{1'b0}};
            last_sel_r <= {SEL_W{1'b0}};
            out_data_r <= {DATA_WIDTH{1'b0}};
            xfer_cnt_r <= 8'd0;
        end else begin
            state_r <= state_nxt_s;
            if (xfer_s) begin
                out_data_r <= mux_out_s;
                ptr_r      <= winner_s + 2'd1;
                xfer_cnt_r <= xfer_cnt_r + 8'd1;
            end
            if (any_req_s) begin
                last_sel_r <= winner_s;
            end
        end
    end

    assign out_valid = (state_r == BUSY);
    assign out_data  = out_data_r;
    assign xfer_cnt  = xfer_cnt_r;

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Directed self-checking bench for rr_mux_arbiter with hand-computed expectations.
module tb_rr_mux_arbiter;

    logic       clk;
    logic       rst_n;
    logic [3:0] req_valid;
    logic [7:0] req_data0;
    logic [7:0] req_data1;
    logic [7:0] req_data2;
    logic [7:0] req_data3;
    logic [3:0] req_ready;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic [1:0] grant_sel;
    logic [7:0] xfer_cnt;

    int checks;
    int errors;

    rr_mux_arbiter #(
        .DATA_WIDTH (8)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_data0 (req_data0),
        .req_data1 (req_data1),
        .req_data2 (req_data2),
        .req_data3 (req_data3),
        .req_ready (req_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .grant_sel (grant_sel),
        .xfer_cnt  (xfer_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        rst_n     = 1'b0;
        req_valid = 4'b1111;
        out_ready = 1'b0;
        req_data0 = 8'hA0;
        req_data1 = 8'hA1;
        req_data2 = 8'hA2;
        req_data3 = 8'hA3;
        #2;
        chk("rst_req_ready", 32'(req_ready), 32'h0);
        chk("rst_out_valid", 32'(out_valid), 32'h0);
        chk("rst_xfer_cnt",  32'(xfer_cnt),  32'h0);
        chk("rst_out_data",  32'(out_data),  32'h0);
        chk("rst_grant_sel", 32'(grant_sel), 32'h0);
        tick();
        tick();
        rst_n = 1'b1;

        // Fairness: all four request, downstream always ready.
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            req_valid = 4'b1111;
            #1;
            chk("fair_req_ready", 32'(req_ready), 32'(4'b0001 << (i % 4)));
            tick();
            chk("fair_out_data",  32'(out_data),  32'(8'hA0 + 8'(i % 4)));
            chk("fair_out_valid", 32'(out_valid), 32'h1);
            chk("fair_xfer_cnt",  32'(xfer_cnt),  32'(i + 1));
        end

        // Stall: take 0x55 from requester 2, then block downstream.
        req_data2 = 8'h55;
        req_valid = 4'b0100;
        #1;
        chk("stall_acc_ready", 32'(req_ready), 32'h4);
        chk("stall_acc_grant", 32'(grant_sel), 32'h2);
        tick();
        chk("stall_acc_data", 32'(out_data), 32'h55);
        chk("stall_acc_ptr",  32'(dut.ptr_r), 32'h3);
        out_ready = 1'b0;
        req_valid = 4'b0011;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("stall_req_ready", 32'(req_ready), 32'h0);
            tick();
            chk("stall_out_data",  32'(out_data),   32'h55);
            chk("stall_out_valid", 32'(out_valid),  32'h1);
            chk("stall_ptr",       32'(dut.ptr_r),  32'h3);
            chk("stall_xfer_cnt",  32'(xfer_cnt),   32'd9);
        end
        out_ready = 1'b1;
        #1;
        chk("release_req_ready", 32'(req_ready), 32'h1);
        chk("release_grant",     32'(grant_sel), 32'h0);
        tick();
        chk("release_out_data", 32'(out_data),  32'hA0);
        chk("release_ptr",      32'(dut.ptr_r), 32'h1);
        chk("release_xfer_cnt", 32'(xfer_cnt),  32'd10);

        // Skip: ptr=1 but only requester 0 is active.
        req_data0 = 8'h3C;
        req_valid = 4'b0001;
        #1;
        chk("skip_req_ready", 32'(req_ready), 32'h1);
        chk("skip_grant",     32'(grant_sel), 32'h0);
        tick();
        chk("skip_out_data", 32'(out_data),  32'h3C);
        chk("skip_ptr",      32'(dut.ptr_r), 32'h1);

        // Grant held when requests vanish, then drain to IDLE.
        req_valid = 4'b1000;
        #1;
        chk("hold_pre_grant", 32'(grant_sel), 32'h3);
        tick();
        chk("hold_pre_ptr", 32'(dut.ptr_r), 32'h0);
        req_valid = 4'b0000;
        #1;
        chk("hold_grant",     32'(grant_sel), 32'h3);
        chk("hold_req_ready", 32'(req_ready), 32'h0);
        tick();
        chk("drain_out_valid", 32'(out_valid), 32'h0);
        chk("drain_out_data",  32'(out_data),  32'hA3);
        chk("drain_xfer_cnt",  32'(xfer_cnt),  32'd12);

        // Mid-operation asynchronous reset while BUSY.
        req_valid = 4'b0100;
        tick();
        chk("pre_rst_out_valid", 32'(out_valid), 32'h1);
        req_valid = 4'b0000;
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_out_valid", 32'(out_valid), 32'h0);
        chk("async_rst_out_data",  32'(out_data),  32'h0);
        chk("async_rst_xfer_cnt",  32'(xfer_cnt),  32'h0);
        #2;
        rst_n     = 1'b1;
        req_valid = 4'b0110;
        #1;
        chk("post_rst_req_ready", 32'(req_ready), 32'h2);
        chk("post_rst_grant",     32'(grant_sel), 32'h1);
        tick();
        chk("post_rst_out_data", 32'(out_data), 32'hA1);
        chk("post_rst_xfer_cnt", 32'(xfer_cnt), 32'h1);

        // Wrap: single requester 1 every cycle until 256 transfers total.
        req_valid = 4'b0010;
        for (int j = 2; j <= 256; j++) begin
            #1;
            chk("wrap_req_ready", 32'(req_ready), 32'h2);
            tick();
            chk("wrap_xfer_cnt", 32'(xfer_cnt), 32'(j % 256));
        end
        chk("wrap_out_valid", 32'(out_valid), 32'h1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rr_mux_arbiter.md
RR_MUX_ARBITER -- requirements
Module: rr_mux_arbiter

Interface
REQ-001 Parameter DATA_WIDTH, default 8: width of every data port.
REQ-002 clk  input  1  sole clock; all state updates on the rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 req_valid  input  4  per-requester valid; bit i belongs to requester i.
REQ-005 req_data0..req_data3  input  DATA_WIDTH each  requester payloads.
REQ-006 req_ready  output  4  per-requester accept; at most one bit is high.
REQ-007 out_valid  output  1  registered output holds a payload.
REQ-008 out_ready  input  1  downstream accept.
REQ-009 out_data  output  DATA_WIDTH  registered payload.
REQ-010 grant_sel  output  2  index of the current winner; drives the 4:1 mux select.
REQ-011 xfer_cnt  output  8  count of accepted input transfers.

Function
REQ-012 The block SHALL share one 4:1 data mux between four requesters using a round-robin arbiter and a one-entry output register.
REQ-013 FSM states SHALL be IDLE (out_valid=0) and BUSY (out_valid=1).
REQ-014 can_accept SHALL be (state==IDLE) or out_ready.
REQ-015 The winner SHALL be the first requester with req_valid high, scanning from index ptr upward modulo 4; grant_sel SHALL equal the winner index and SHALL hold its last value when no request is pending.
REQ-016 req_ready[i] SHALL be can_accept AND req_valid is nonzero AND i equals the winner; it is combinational, with no registered latency.
REQ-017 An input transfer SHALL occur when req_valid[i] and req_ready[i] are both high; on that edge out_data SHALL load the mux output, the state SHALL become BUSY, ptr SHALL become (winner+1) mod 4, and xfer_cnt SHALL increment.
REQ-018 Latency from input transfer to out_valid SHALL be exactly one cycle.
REQ-019 In BUSY with out_ready=1 and no req_valid, the state SHALL go to IDLE on the next edge.
REQ-020 In BUSY with out_ready=1 and any req_valid, the block SHALL accept a new transfer in the same cycle and stay in BUSY, so back-to-back transfers sustain one per cycle.
REQ-021 In BUSY with out_ready=0, out_data, out_valid, ptr and req_ready (all 0) SHALL hold.
REQ-022 ptr SHALL change only on an input transfer and never while stalled.
REQ-023 xfer_cnt SHALL wrap from 255 to 0 without saturating.
REQ-024 A requester that drops req_valid before it is granted SHALL lose no slot; arbitration SHALL be re-evaluated every cycle.
REQ-025 A single active requester SHALL be granted every accepting cycle regardless of ptr.

Reset
REQ-026 While rst_n=0: state=IDLE, out_valid=0, out_data=0, ptr=0, grant_sel=0, xfer_cnt=0, req_ready=0.
REQ-027 A reset asserted mid-operation SHALL discard any held payload immediately, without waiting for a clock edge.
REQ-028 After rst_n deasserts, the first edge SHALL behave as IDLE with ptr=0.

Structure
REQ-029 The shared package SHALL hold the state enum (IDLE, BUSY), the requester-count constant (4) and the select-width constant (2).
REQ-030 The data path SHALL instantiate the existing 4:1 mux sub-module mux_2, with sel=grant_sel; the arbiter SHALL contain no duplicated mux logic.
REQ-031 The RTL SHALL have one sequential process for state, ptr, out_data and xfer_cnt, and combinational logic for the winner and req_ready.

Verification
REQ-032 Reset: drive req_valid=4'b1111 with rst_n=0 -> req_ready=0, out_valid=0, xfer_cnt=0.
REQ-033 Fairness: req_valid=4'b1111, data 0xA0..0xA3, out_ready=1 for 8 cycles -> out_data sequence 0xA0,0xA1,0xA2,0xA3,0xA0..., one per cycle.
REQ-034 Stall: accept 0x55 from requester 2, then out_ready=0 for 5 cycles with req_valid=4'b0011 -> out_data stays 0x55, req_ready=0, ptr stays 3; on release, requester 0 wins.
REQ-035 Skip: ptr=1, req_valid=4'b0001 -> requester 0 is granted, grant_sel=0, and ptr becomes 1.
REQ-036 Wrap: 256 single-requester transfers -> xfer_cnt returns to 0.
REQ-037 Mid-operation reset: pulse rst_n low asynchronously while BUSY -> out_valid=0 immediately, and the first grant after reset goes to the lowest active index.
